// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and access-size mask for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? 4'b0001 :
           (f3 == F3_H || f3 == F3_HU) ? 4'b0011 :
           (f3 == F3_W)                ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement of store data/enables and extension of merged load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  m8_o,
  output logic [63:0] d64_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);
  logic [31:0] r;
  always_comb begin
    m8_o    = {4'b0000, size_mask(funct3_i)} << off_i;
    d64_o   = {32'b0, wdata_i} << {off_i, 3'b000};
    split_o = |m8_o[7:4];
    r       = 32'({hi_i, lo_i} >> {off_i, 3'b000});
    rdata_o = (funct3_i == F3_B)  ? {{24{r[7]}}, r[7:0]}   :
              (funct3_i == F3_BU) ? {24'b0, r[7:0]}        :
              (funct3_i == F3_H)  ? {{16{r[15]}}, r[15:0]} :
              (funct3_i == F3_HU) ? {16'b0, r[15:0]}       : r;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request data-memory initiator that splits word-crossing accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddress,
  output logic [ADDR_W-1:0] mem_waddress,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
  lsu_state_t        state_q, state_d;
  logic              store_q, store_d, accept, err, split;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d, word0, word1;
  logic [DATA_W-1:0] wdata_q, wdata_d, lo_q, hi_q, ext;
  logic [7:0]        m8;
  logic [63:0]       d64;
  // The _d request fields let the memory outputs for ISSUE0 be loaded on the accept edge itself
  always_comb begin
    req_ready = state_q == IDLE && !reset;
    accept    = req_valid && req_ready;
    store_d   = accept ? req_store : store_q;
    f3_d      = accept ? req_funct3 : f3_q;
    addr_d    = accept ? req_addr : addr_q;
    wdata_d   = accept ? req_wdata : wdata_q;
    err       = size_mask(f3_d) == 4'b0000 || (store_d && f3_d[2]);
    word0     = {addr_d[ADDR_W-1:2], 2'b00};
    word1     = word0 + ADDR_W'(4);
    state_d   = (state_q == IDLE)   ? (accept ? (err ? RESP : ISSUE0) : IDLE) :
                (state_q == ISSUE0) ? (split ? ISSUE1 : store_q ? RESP : WAIT) :
                (state_q == ISSUE1) ? (store_q ? RESP : WAIT) :
                (state_q == WAIT)   ? RESP : IDLE;
  end
  lsu_align u_align (
    .funct3_i(f3_d),
    .off_i   (addr_d[1:0]),
    .wdata_i (wdata_d),
    .lo_i    (lo_q),
    .hi_i    (hi_q),
    .m8_o    (m8),
    .d64_o   (d64),
    .split_o (split),
    .rdata_o (ext)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_raddress <= '0;
      mem_waddress <= '0;
      mem_wdata    <= '0;
      mem_wr       <= 4'b0000;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mem_wr  <= (store_d && state_d == ISSUE0) ? m8[3:0] :
                 (store_d && state_d == ISSUE1) ? m8[7:4] : 4'b0000;
      if (state_d == ISSUE0 && store_d) begin
        mem_waddress <= word0;
        mem_wdata    <= d64[31:0];
      end
      if (state_d == ISSUE1 && store_d) begin
        mem_waddress <= word1;
        mem_wdata    <= d64[63:32];
      end
      if (state_d == ISSUE0 && !store_d) mem_raddress <= word0;
      if (state_d == ISSUE1 && !store_d) mem_raddress <= word1;
      if (state_q == ISSUE1) lo_q <= mem_rdata;
      if (state_q == WAIT && split) hi_q <= mem_rdata;
      if (state_q == WAIT && !split) lo_q <= mem_rdata;
      resp_valid <= state_q == RESP;
      resp_err   <= state_q == RESP && err;
      resp_rdata <= (state_q == RESP && !store_q && !err) ? ext : '0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table, hand-written and random checks of the LSU against a byte-array memory model
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_raddress, mem_waddress;
  logic [3:0]  mem_wr;
  int tests = 0, fails = 0;
  logic [31:0] mem [128];
  logic [7:0]  ref_mem [512];
  logic [44:0] wlog [$];

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nw;
  } vec_t;
  vec_t tv [16];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddress(mem_raddress), .mem_waddress(mem_waddress), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wr[i]) mem[mem_waddress[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_wr != 4'b0000) wlog.push_back({mem_waddress, mem_wr, mem_wdata});
    mem_rdata <= mem[mem_raddress[8:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [8:0] a, input logic [31:0] v);
    mem[a[8:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[{a[8:2], 2'b00} + 9'(i)] = v[8*i +: 8];
  endtask

  // Reference: byte-granular little-endian memory, addresses wrap modulo 512
  function automatic void ref_acc(input logic st, input logic [2:0] f3, input logic [8:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er, output int lat);
    int n;
    logic [31:0] v;
    er  = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && f3 >= 3'd4);
    rd  = '0;
    lat = 1;
    if (er) return;
    n   = (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
    lat = (int'(a[1:0]) + n > 4 ? 1 : 0) + (st ? 2 : 3);
    v   = '0;
    for (int i = 0; i < n; i++) begin
      if (st) ref_mem[a + 9'(i)] = wd[8*i +: 8];
      else v[8*i +: 8] = ref_mem[a + 9'(i)];
    end
    if (!st)
      rd = (f3 == 3'd0) ? 32'($signed(v[7:0])) :
           (f3 == 3'd1) ? 32'($signed(v[15:0])) : v;
  endfunction

  task automatic run(input logic st, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) lat = 99;
    @(posedge clk);
    #1 chk("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, erd, wd;
    logic er, eer, st;
    logic [2:0] f3;
    logic [8:0] a;
    int lat, elat, n0, viol, bad;

    tv[0]  = '{1'b0, 3'd0, 9'h013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0};
    tv[1]  = '{1'b0, 3'd4, 9'h013, 32'h0,        32'h00000080, 1'b0, 3, 0};
    tv[2]  = '{1'b0, 3'd1, 9'h012, 32'h0,        32'hFFFF80FF, 1'b0, 3, 0};
    tv[3]  = '{1'b0, 3'd2, 9'h010, 32'h0,        32'h80FF1234, 1'b0, 3, 0};
    tv[4]  = '{1'b1, 3'd1, 9'h013, 32'h0000ABCD, 32'h0,        1'b0, 3, 2};
    tv[5]  = '{1'b0, 3'd1, 9'h013, 32'h0,        32'hFFFFABCD, 1'b0, 4, 0};
    tv[6]  = '{1'b0, 3'd5, 9'h014, 32'h0,        32'h000000AB, 1'b0, 3, 0};
    tv[7]  = '{1'b0, 3'd5, 9'h016, 32'h0,        32'h0000CAFE, 1'b0, 3, 0};
    tv[8]  = '{1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    tv[9]  = '{1'b0, 3'd2, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    tv[10] = '{1'b0, 3'd2, 9'h1FE, 32'h0,        32'h77881122, 1'b0, 4, 0};
    tv[11] = '{1'b0, 3'd3, 9'h004, 32'h0,        32'h0,        1'b1, 1, 0};
    tv[12] = '{1'b1, 3'd4, 9'h008, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
    tv[13] = '{1'b1, 3'd5, 9'h00A, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
    tv[14] = '{1'b0, 3'd7, 9'h000, 32'h0,        32'h0,        1'b1, 1, 0};
    tv[15] = '{1'b0, 3'd0, 9'h1FF, 32'h0,        32'h00000011, 1'b0, 3, 0};

    for (int i = 0; i < 128; i++) set_word(9'(i * 4), $urandom);
    set_word(9'h010, 32'h80FF1234);
    set_word(9'h014, 32'hCAFE0000);
    set_word(9'h1FC, 32'h11223344);
    set_word(9'h000, 32'h55667788);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_raddr", 32'(mem_raddress), 32'd0);
    chk("rst_waddr", 32'(mem_waddress), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      n0 = wlog.size();
      ref_acc(tv[i].st, tv[i].f3, tv[i].a, tv[i].wd, erd, eer, elat);
      run(tv[i].st, tv[i].f3, tv[i].a, tv[i].wd, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d err", i), 32'(er), 32'(tv[i].er));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d writes", i), 32'(wlog.size() - n0), 32'(tv[i].nw));
    end
    chk("sh_w0", wlog[0][44:0], {9'h010, 4'b1000, 32'hCD000000});
    chk("sh_w1", wlog[1][44:0], {9'h014, 4'b0001, 32'h000000AB});
    chk("sw_w", wlog[2][44:0], {9'h010, 4'b1111, 32'hDEADBEEF});

    // Reset during ISSUE0 of a split word store: only the first word lands
    wd = $urandom;
    n0 = wlog.size();
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'd2; req_addr = 9'h012; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort_wr", 32'(mem_wr), 32'd0);
    chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1 chk("abort_ready", 32'(req_ready), 32'd1);
    ref_mem[9'h012] = wd[7:0];
    ref_mem[9'h013] = wd[15:8];
    viol = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (resp_valid || mem_wr != 4'b0000) viol++;
    end
    chk("abort_quiet", 32'(viol), 32'd0);
    chk("abort_writes", 32'(wlog.size() - n0), 32'd1);
    chk("abort_w0", wlog[n0][44:32], {9'h010, 4'b1100});

    // Reset and request on the same edge: request dropped
    n0 = wlog.size();
    @(negedge clk);
    reset = 1'b1;
    req_store = 1'b1; req_funct3 = 3'd2; req_addr = 9'h040; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    req_valid = 1'b0;
    viol = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (resp_valid || mem_wr != 4'b0000 || !req_ready) viol++;
    end
    chk("rst_wins_quiet", 32'(viol), 32'd0);
    chk("rst_wins_writes", 32'(wlog.size() - n0), 32'd0);

    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = 9'($urandom);
      wd = $urandom;
      ref_acc(st, f3, a, wd, erd, eer, elat);
      run(st, f3, a, wd, rd, er, lat);
      chk($sformatf("rnd%0d rdata", i), rd, erd);
      chk($sformatf("rnd%0d err", i), 32'(er), 32'(eer));
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
    end

    bad = 0;
    for (int w = 0; w < 128; w++)
      if (mem[w] !== {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]}) bad++;
    chk("mem_image_bad_words", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
